cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
- Combined decode/execute slice of the 8-bit accumulator CPU. It holds the instruction decoder, the 8-bit ALU, the 3-to-8 register write-enable decoder and a registered Z/C flag pair.
- Upstream: the 16-bit instruction word from program memory. Downstream: program counter, accumulator, R0..R7, operand muxes and RAM.
- Everything is combinational except the flags register.

Parameters:
- DATA_WIDTH, 8, ALU operand/result width.
- OP_WIDTH, 4, ALU operation code width.

Ports:
- CLK  in  1  system clock; flags update on the rising edge.
- RST  in  1  asynchronous, active-low reset (0 = reset).
- INSTR  in  16  instruction word: [15:11] opcode, [10:8] register select, [7:0] immediate, [3:0] jump target.
- A_IN  in  DATA_WIDTH  ALU operand A (external mux: ACC when MUX_SEL=0, immediate when 1).
- B_IN  in  DATA_WIDTH  ALU operand B (external mux: selected Rn when MEM_SEL=0, RAM data when 1).
- ALU_OUT  out  DATA_WIDTH  ALU result.
- OP  out  OP_WIDTH  decoded ALU operation.
- MUX_SEL  out  1  selects the immediate as operand A.
- MEM_SEL  out  1  selects RAM data as operand B.
- CE_ACC  out  1  accumulator load enable.
- REG_WR  out  1  register-file write request.
- CE_R  out  8  one-hot write enable for R7..R0.
- CE_RAM  out  1  RAM write enable; address is R0, data is ACC.
- CE_PC  out  1  PC load of INSTR[3:0].
- RESET_INSTR  out  1  software reset request to the PC.
- FLAG_Z, FLAG_C  out  1 each  registered zero and carry flags.

Behaviour:
- Opcode map. Outputs not listed for an opcode are 0; OP defaults to 0 (PASS_A).
  - 00000 NOP: no outputs asserted.
  - 00001 LDI: MUX_SEL=1, OP=PASS_A, CE_ACC=1.
  - 00010 STR: REG_WR=1 (Rn <= ACC).
  - 00011 LDR: OP=PASS_B, CE_ACC=1.
  - 00100..01000 ADD, SUB, AND, OR, XOR of ACC with Rn: OP=2..6 respectively, CE_ACC=1.
  - 01001 ADDI: MUX_SEL=1, OP=ADD, CE_ACC=1.
  - 01010..01110 NOT, SHL, SHR, INC, DEC on ACC: OP=7..B respectively, CE_ACC=1.
  - 01111 LDM: MEM_SEL=1, OP=PASS_B, CE_ACC=1.
  - 10000 STM: CE_RAM=1.
  - 10001 JMP: CE_PC=1.
  - 10010 JZ: CE_PC=FLAG_Z.
  - 10011 JC: CE_PC=FLAG_C.
  - 11111 RST: RESET_INSTR=1.
  - All other opcodes decode as NOP.
- ALU operations (combinational). r is the 9-bit result; ALU_OUT=r[7:0]; carry is c.
  - 0 PASS_A: r=A, c=0.
  - 1 PASS_B: r=B, c=0.
  - 2 ADD: r=A+B, c=r[8].
  - 3 SUB: r=A-B; c=1 on borrow (A<B).
  - 4 AND, 5 OR, 6 XOR: bitwise, c=0.
  - 7 NOT: r=~A, c=0.
  - 8 SHL: r=A<<1, c=A[7].
  - 9 SHR: logical shift right, c=A[0].
  - A INC: r=A+1, c on FF->00.
  - B DEC: r=A-1, c on 00->FF.
  - C..F: ALU_OUT=00, c=0.
- Register write decoder: CE_R[k]=1 iff REG_WR=1 and INSTR[10:8]==k. CE_R=00 when REG_WR=0. Never more than one bit is set.
- Flags:
  - On a rising CLK edge with CE_ACC=1: FLAG_Z <= (ALU_OUT==0), FLAG_C <= c.
  - With CE_ACC=0 the flags hold.
  - Flags are not affected by STR, STM, jumps or NOP.
- Reset:
  - RST=0 clears FLAG_Z and FLAG_C to 0 immediately, independent of CLK, and holds them at 0 while low.
  - Combinational outputs keep following INSTR during reset, so JZ/JC yield CE_PC=0 during reset.
  - Flags resume updating on the first rising edge after RST returns high.
- Latency: all control outputs and ALU_OUT are zero-cycle combinational. A flag change affects JZ/JC from the cycle after the flag-setting instruction.

Test Plan:
- Reset: RST=0 with INSTR=ADD, A=FF, B=01 and clocking → FLAG_Z=0 and FLAG_C=0 throughout. After RST=1 and one edge → FLAG_Z=1, FLAG_C=1, ALU_OUT=00.
- Decode sweep over all 32 opcodes, INSTR[10:8]=5:
  - Each control vector matches the opcode map.
  - STR gives CE_R=0010_0000.
  - Undefined opcodes give all outputs 0.
  - 11111 gives RESET_INSTR=1 only.
- ALU boundaries:
  - SUB 05-07 → FE, c=1.
  - SHL 81 → 02, c=1.
  - SHR 01 → 00, c=1.
  - INC FF → 00, c=1.
  - DEC 00 → FF, c=1.
  - XOR A5^5A → FF, c=0.
  - OP=C → 00.
- Conditional jump:
  - DEC with A=01, clock, then JZ → CE_PC=1.
  - Then ADD 01+01, clock, JZ → CE_PC=0 and JC → CE_PC=0.
- Flag hold: set Z=1, then clock STR, STM, JMP → flags unchanged. CE_R one-hot on STR for each of INSTR[10:8]=0..7.
- Async reset mid-operation: assert RST low between clock edges after Z=1 → Z clears immediately. JZ then gives CE_PC=0.

Source files
------------

// File: rtl/cpu_control_unit.sv
// Decode/execute slice of the 8-bit accumulator CPU: instruction decoder,
// ALU, register write-enable decoder and the registered Z/C flag pair.
module cpu_control_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [15:0]           INSTR,
  input  logic [DATA_WIDTH-1:0] A_IN,
  input  logic [DATA_WIDTH-1:0] B_IN,
  output logic [DATA_WIDTH-1:0] ALU_OUT,
  output logic [OP_WIDTH-1:0]   OP,
  output logic                  MUX_SEL,
  output logic                  MEM_SEL,
  output logic                  CE_ACC,
  output logic                  REG_WR,
  output logic [7:0]            CE_R,
  output logic                  CE_RAM,
  output logic                  CE_PC,
  output logic                  RESET_INSTR,
  output logic                  FLAG_Z,
  output logic                  FLAG_C
);

  // Opcodes (INSTR[15:11])
  localparam logic [4:0] OPC_NOP  = 5'b00000;
  localparam logic [4:0] OPC_LDI  = 5'b00001;
  localparam logic [4:0] OPC_STR  = 5'b00010;
  localparam logic [4:0] OPC_LDR  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_SUB  = 5'b00101;
  localparam logic [4:0] OPC_AND  = 5'b00110;
  localparam logic [4:0] OPC_OR   = 5'b00111;
  localparam logic [4:0] OPC_XOR  = 5'b01000;
  localparam logic [4:0] OPC_ADDI = 5'b01001;
  localparam logic [4:0] OPC_NOT  = 5'b01010;
  localparam logic [4:0] OPC_SHL  = 5'b01011;
  localparam logic [4:0] OPC_SHR  = 5'b01100;
  localparam logic [4:0] OPC_INC  = 5'b01101;
  localparam logic [4:0] OPC_DEC  = 5'b01110;
  localparam logic [4:0] OPC_LDM  = 5'b01111;
  localparam logic [4:0] OPC_STM  = 5'b10000;
  localparam logic [4:0] OPC_JMP  = 5'b10001;
  localparam logic [4:0] OPC_JZ   = 5'b10010;
  localparam logic [4:0] OPC_JC   = 5'b10011;
  localparam logic [4:0] OPC_RST  = 5'b11111;

  // ALU operation codes
  localparam logic [OP_WIDTH-1:0] ALU_PASS_A = OP_WIDTH'(4'h0);
  localparam logic [OP_WIDTH-1:0] ALU_PASS_B = OP_WIDTH'(4'h1);
  localparam logic [OP_WIDTH-1:0] ALU_ADD    = OP_WIDTH'(4'h2);
  localparam logic [OP_WIDTH-1:0] ALU_SUB    = OP_WIDTH'(4'h3);
  localparam logic [OP_WIDTH-1:0] ALU_AND    = OP_WIDTH'(4'h4);
  localparam logic [OP_WIDTH-1:0] ALU_OR     = OP_WIDTH'(4'h5);
  localparam logic [OP_WIDTH-1:0] ALU_XOR    = OP_WIDTH'(4'h6);
  localparam logic [OP_WIDTH-1:0] ALU_NOT    = OP_WIDTH'(4'h7);
  localparam logic [OP_WIDTH-1:0] ALU_SHL    = OP_WIDTH'(4'h8);
  localparam logic [OP_WIDTH-1:0] ALU_SHR    = OP_WIDTH'(4'h9);
  localparam logic [OP_WIDTH-1:0] ALU_INC    = OP_WIDTH'(4'hA);
  localparam logic [OP_WIDTH-1:0] ALU_DEC    = OP_WIDTH'(4'hB);

  localparam logic [DATA_WIDTH:0] ONE_EXT = (DATA_WIDTH+1)'(1);

  logic [4:0]          opcode;
  logic [2:0]          reg_sel;
  logic [DATA_WIDTH:0] alu_r;
  logic                alu_c;
  logic                unused_instr;

  assign opcode       = INSTR[15:11];
  assign reg_sel      = INSTR[10:8];
  // Immediate and jump target are consumed by the datapath outside this block.
  assign unused_instr = ^INSTR[7:0];

  // Instruction decode: every output defaults to inactive, undefined opcodes act as NOP.
  always_comb begin
    OP          = ALU_PASS_A;
    MUX_SEL     = 1'b0;
    MEM_SEL     = 1'b0;
    CE_ACC      = 1'b0;
    REG_WR      = 1'b0;
    CE_RAM      = 1'b0;
    CE_PC       = 1'b0;
    RESET_INSTR = 1'b0;
    case (opcode)
      OPC_NOP:  ;
      OPC_LDI:  begin MUX_SEL = 1'b1; OP = ALU_PASS_A; CE_ACC = 1'b1; end
      OPC_STR:  REG_WR = 1'b1;
      OPC_LDR:  begin OP = ALU_PASS_B; CE_ACC = 1'b1; end
      OPC_ADD:  begin OP = ALU_ADD; CE_ACC = 1'b1; end
      OPC_SUB:  begin OP = ALU_SUB; CE_ACC = 1'b1; end
      OPC_AND:  begin OP = ALU_AND; CE_ACC = 1'b1; end
      OPC_OR:   begin OP = ALU_OR;  CE_ACC = 1'b1; end
      OPC_XOR:  begin OP = ALU_XOR; CE_ACC = 1'b1; end
      OPC_ADDI: begin MUX_SEL = 1'b1; OP = ALU_ADD; CE_ACC = 1'b1; end
      OPC_NOT:  begin OP = ALU_NOT; CE_ACC = 1'b1; end
      OPC_SHL:  begin OP = ALU_SHL; CE_ACC = 1'b1; end
      OPC_SHR:  begin OP = ALU_SHR; CE_ACC = 1'b1; end
      OPC_INC:  begin OP = ALU_INC; CE_ACC = 1'b1; end
      OPC_DEC:  begin OP = ALU_DEC; CE_ACC = 1'b1; end
      OPC_LDM:  begin MEM_SEL = 1'b1; OP = ALU_PASS_B; CE_ACC = 1'b1; end
      OPC_STM:  CE_RAM = 1'b1;
      OPC_JMP:  CE_PC = 1'b1;
      OPC_JZ:   CE_PC = FLAG_Z;
      OPC_JC:   CE_PC = FLAG_C;
      OPC_RST:  RESET_INSTR = 1'b1;
      default:  ;
    endcase
  end

  // One-hot register write enable from the register-select field.
  always_comb begin
    CE_R = 8'h00;
    if (REG_WR) CE_R[reg_sel] = 1'b1;
  end

  // ALU: 9-bit result so add/subtract carry and borrow fall out of the top bit.
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    case (OP)
      ALU_PASS_A: alu_r = {1'b0, A_IN};
      ALU_PASS_B: alu_r = {1'b0, B_IN};
      ALU_ADD:    begin alu_r = {1'b0, A_IN} + {1'b0, B_IN}; alu_c = alu_r[DATA_WIDTH]; end
      ALU_SUB:    begin alu_r = {1'b0, A_IN} - {1'b0, B_IN}; alu_c = alu_r[DATA_WIDTH]; end
      ALU_AND:    alu_r = {1'b0, A_IN & B_IN};
      ALU_OR:     alu_r = {1'b0, A_IN | B_IN};
      ALU_XOR:    alu_r = {1'b0, A_IN ^ B_IN};
      ALU_NOT:    alu_r = {1'b0, ~A_IN};
      ALU_SHL:    begin alu_r = {1'b0, A_IN[DATA_WIDTH-2:0], 1'b0}; alu_c = A_IN[DATA_WIDTH-1]; end
      ALU_SHR:    begin alu_r = {2'b00, A_IN[DATA_WIDTH-1:1]}; alu_c = A_IN[0]; end
      ALU_INC:    begin alu_r = {1'b0, A_IN} + ONE_EXT; alu_c = alu_r[DATA_WIDTH]; end
      ALU_DEC:    begin alu_r = {1'b0, A_IN} - ONE_EXT; alu_c = alu_r[DATA_WIDTH]; end
      default:    begin alu_r = '0; alu_c = 1'b0; end
    endcase
  end

  assign ALU_OUT = alu_r[DATA_WIDTH-1:0];

  // Flags capture the ALU status only when the accumulator loads.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      FLAG_Z <= 1'b0;
      FLAG_C <= 1'b0;
    end else if (CE_ACC) begin
      FLAG_Z <= (ALU_OUT == '0);
      FLAG_C <= alu_c;
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: reset, decode sweep, ALU edges,
// conditional jumps, flag hold and asynchronous reset.
module tb_cpu_control_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] INSTR;
  logic [7:0]  A_IN, B_IN;
  logic [7:0]  ALU_OUT;
  logic [3:0]  OP;
  logic        MUX_SEL, MEM_SEL, CE_ACC, REG_WR, CE_RAM, CE_PC, RESET_INSTR;
  logic [7:0]  CE_R;
  logic        FLAG_Z, FLAG_C;

  int total = 0;
  int bad   = 0;

  cpu_control_unit #(.DATA_WIDTH(8), .OP_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .INSTR(INSTR), .A_IN(A_IN), .B_IN(B_IN),
    .ALU_OUT(ALU_OUT), .OP(OP), .MUX_SEL(MUX_SEL), .MEM_SEL(MEM_SEL),
    .CE_ACC(CE_ACC), .REG_WR(REG_WR), .CE_R(CE_R), .CE_RAM(CE_RAM),
    .CE_PC(CE_PC), .RESET_INSTR(RESET_INSTR), .FLAG_Z(FLAG_Z), .FLAG_C(FLAG_C)
  );

  // 10 ns clock
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for the next rising edge and settle just after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [4:0] opc, input logic [2:0] rs);
    return {opc, rs, 8'h00};
  endfunction

  // Hand-written opcode map with flags at 0:
  // {MUX_SEL, MEM_SEL, CE_ACC, REG_WR, CE_RAM, CE_PC, RESET_INSTR, OP[3:0]}
  function automatic logic [10:0] exp_dec(input logic [4:0] opc);
    case (opc)
      5'h00: return 11'b0000000_0000;
      5'h01: return 11'b1010000_0000;
      5'h02: return 11'b0001000_0000;
      5'h03: return 11'b0010000_0001;
      5'h04: return 11'b0010000_0010;
      5'h05: return 11'b0010000_0011;
      5'h06: return 11'b0010000_0100;
      5'h07: return 11'b0010000_0101;
      5'h08: return 11'b0010000_0110;
      5'h09: return 11'b1010000_0010;
      5'h0A: return 11'b0010000_0111;
      5'h0B: return 11'b0010000_1000;
      5'h0C: return 11'b0010000_1001;
      5'h0D: return 11'b0010000_1010;
      5'h0E: return 11'b0010000_1011;
      5'h0F: return 11'b0110000_0001;
      5'h10: return 11'b0000100_0000;
      5'h11: return 11'b0000010_0000;
      5'h1F: return 11'b0000001_0000;
      default: return 11'b0000000_0000;
    endcase
  endfunction

  logic [10:0] got_dec;
  logic [7:0]  one_hot;

  initial begin
    RST   = 1'b0;
    INSTR = mk(5'b00100, 3'd0);
    A_IN  = 8'hFF;
    B_IN  = 8'h01;

    // Reset held across clock edges with an ADD that would set Z and C.
    step();
    check("rst_z_1", 32'(FLAG_Z), 32'd0);
    check("rst_c_1", 32'(FLAG_C), 32'd0);
    step();
    check("rst_z_2", 32'(FLAG_Z), 32'd0);
    check("rst_c_2", 32'(FLAG_C), 32'd0);
    check("rst_alu", 32'(ALU_OUT), 32'h00);

    // Decode sweep while flags are held at 0 by reset.
    for (int o = 0; o < 32; o++) begin
      INSTR = mk(5'(o), 3'd5);
      #1;
      got_dec = {MUX_SEL, MEM_SEL, CE_ACC, REG_WR, CE_RAM, CE_PC, RESET_INSTR, OP};
      check($sformatf("dec_%02h", o), 32'(got_dec), 32'(exp_dec(5'(o))));
      check($sformatf("cer_%02h", o), 32'(CE_R), (o == 2) ? 32'h20 : 32'h00);
    end

    // Release reset; first edge applies ADD FF+01.
    INSTR = mk(5'b00100, 3'd0);
    A_IN  = 8'hFF;
    B_IN  = 8'h01;
    #2;
    RST = 1'b1;
    step();
    check("post_rst_z", 32'(FLAG_Z), 32'd1);
    check("post_rst_c", 32'(FLAG_C), 32'd1);
    check("post_rst_alu", 32'(ALU_OUT), 32'h00);

    // ALU boundaries
    INSTR = mk(5'b00101, 3'd0); A_IN = 8'h05; B_IN = 8'h07; #1;
    check("sub_out", 32'(ALU_OUT), 32'hFE);
    step();
    check("sub_c", 32'(FLAG_C), 32'd1);
    check("sub_z", 32'(FLAG_Z), 32'd0);

    INSTR = mk(5'b01011, 3'd0); A_IN = 8'h81; #1;
    check("shl_out", 32'(ALU_OUT), 32'h02);
    step();
    check("shl_c", 32'(FLAG_C), 32'd1);

    INSTR = mk(5'b01100, 3'd0); A_IN = 8'h01; #1;
    check("shr_out", 32'(ALU_OUT), 32'h00);
    step();
    check("shr_c", 32'(FLAG_C), 32'd1);
    check("shr_z", 32'(FLAG_Z), 32'd1);

    INSTR = mk(5'b01101, 3'd0); A_IN = 8'hFF; #1;
    check("inc_out", 32'(ALU_OUT), 32'h00);
    step();
    check("inc_c", 32'(FLAG_C), 32'd1);

    // JC taken with C=1
    INSTR = mk(5'b10011, 3'd0); #1;
    check("jc_taken", 32'(CE_PC), 32'd1);

    INSTR = mk(5'b01110, 3'd0); A_IN = 8'h00; #1;
    check("dec_out", 32'(ALU_OUT), 32'hFF);
    step();
    check("dec_c", 32'(FLAG_C), 32'd1);
    check("dec_z", 32'(FLAG_Z), 32'd0);

    INSTR = mk(5'b01000, 3'd0); A_IN = 8'hA5; B_IN = 8'h5A; #1;
    check("xor_out", 32'(ALU_OUT), 32'hFF);
    step();
    check("xor_c", 32'(FLAG_C), 32'd0);

    // Other ALU results: ADD, AND, OR, NOT, LDR, LDI
    INSTR = mk(5'b00100, 3'd0); A_IN = 8'h3C; B_IN = 8'h0F; #1;
    check("add_out", 32'(ALU_OUT), 32'h4B);
    INSTR = mk(5'b00110, 3'd0); #1;
    check("and_out", 32'(ALU_OUT), 32'h0C);
    INSTR = mk(5'b00111, 3'd0); #1;
    check("or_out", 32'(ALU_OUT), 32'h3F);
    INSTR = mk(5'b01010, 3'd0); #1;
    check("not_out", 32'(ALU_OUT), 32'hC3);
    INSTR = mk(5'b00011, 3'd0); #1;
    check("ldr_out", 32'(ALU_OUT), 32'h0F);
    INSTR = mk(5'b00001, 3'd0); #1;
    check("ldi_out", 32'(ALU_OUT), 32'h3C);

    // Conditional jump: DEC 01 -> Z=1, then JZ taken
    INSTR = mk(5'b01110, 3'd0); A_IN = 8'h01; step();
    INSTR = mk(5'b10010, 3'd0); #1;
    check("jz_taken", 32'(CE_PC), 32'd1);
    INSTR = mk(5'b00100, 3'd0); A_IN = 8'h01; B_IN = 8'h01; step();
    INSTR = mk(5'b10010, 3'd0); #1;
    check("jz_not", 32'(CE_PC), 32'd0);
    INSTR = mk(5'b10011, 3'd0); #1;
    check("jc_not", 32'(CE_PC), 32'd0);

    // Flag hold: INC FF sets Z=1, C=1; STR/STM/JMP must not touch them.
    INSTR = mk(5'b01101, 3'd0); A_IN = 8'hFF; step();
    INSTR = mk(5'b00010, 3'd3); A_IN = 8'h12; B_IN = 8'h34; step();
    check("hold_str_z", 32'(FLAG_Z), 32'd1);
    check("hold_str_c", 32'(FLAG_C), 32'd1);
    INSTR = mk(5'b10000, 3'd0); step();
    check("hold_stm_z", 32'(FLAG_Z), 32'd1);
    check("hold_stm_c", 32'(FLAG_C), 32'd1);
    INSTR = mk(5'b10001, 3'd0); step();
    check("hold_jmp_z", 32'(FLAG_Z), 32'd1);
    check("hold_jmp_c", 32'(FLAG_C), 32'd1);

    // CE_R one-hot for each register
    for (int k = 0; k < 8; k++) begin
      INSTR   = mk(5'b00010, 3'(k));
      one_hot = 8'h01 << k;
      #1;
      check($sformatf("cer_r%0d", k), 32'(CE_R), 32'(one_hot));
    end
    INSTR = mk(5'b00000, 3'd7); #1;
    check("cer_nop", 32'(CE_R), 32'h00);

    // Async reset between edges with Z=1
    step();
    check("pre_async_z", 32'(FLAG_Z), 32'd1);
    #2;
    RST = 1'b0;
    #1;
    check("async_z", 32'(FLAG_Z), 32'd0);
    check("async_c", 32'(FLAG_C), 32'd0);
    INSTR = mk(5'b10010, 3'd0); #1;
    check("async_jz", 32'(CE_PC), 32'd0);
    #3;
    RST = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
